// File: rtl/m_clk_div.sv
// Programmable clock divider: registered 50%-ish divided clock with a handshaked divisor change
// applied only at period boundaries. Define M_CLK_DIV_TICK_EN to add the clk_tick rising-edge pulse.
module m_clk_div #(
  parameter int DIV_W     = 8,
  parameter int RESET_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_req,
  output logic             div_ack,
  output logic             div_err,
  output logic             clk_out
`ifdef M_CLK_DIV_TICK_EN
  ,
  output logic             clk_tick
`endif
);

  typedef enum logic [1:0] {IDLE, PEND, WAIT_LOW} req_state_t;

  req_state_t       state_q, state_d;
  logic [DIV_W-1:0] p_q, p_d;
  logic [DIV_W-1:0] n_q, n_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             clk_out_d;
  logic             ack_d, err_d;
  logic             running, last_phase, at_boundary;

  // A period in progress always runs to completion, even after clk_en drops.
  assign running     = clk_en || (p_q != '0);
  assign last_phase  = (p_q == n_q - DIV_W'(1));
  assign at_boundary = !running || last_phase;

  always_comb begin
    state_d   = state_q;
    p_d       = '0;
    n_d       = n_q;
    pend_d    = pend_q;
    clk_out_d = 1'b0;
    ack_d     = 1'b0;
    err_d     = 1'b0;

    if (running) begin
      clk_out_d = (p_q < (n_q >> 1));
      p_d       = last_phase ? '0 : p_q + DIV_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (div_req) begin
          if (div_val < DIV_W'(2)) begin
            ack_d   = 1'b1;
            err_d   = 1'b1;
            state_d = WAIT_LOW;
          end else begin
            pend_d  = div_val;
            state_d = PEND;
          end
        end
      end
      PEND: begin
        // The new divisor takes effect only where p restarts, so no period is ever truncated.
        if (at_boundary) begin
          n_d     = pend_q;
          p_d     = '0;
          ack_d   = 1'b1;
          state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!div_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      n_q     <= DIV_W'(RESET_DIV);
      pend_q  <= '0;
      clk_out <= 1'b0;
      div_ack <= 1'b0;
      div_err <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      n_q     <= n_d;
      pend_q  <= pend_d;
      clk_out <= clk_out_d;
      div_ack <= ack_d;
      div_err <= err_d;
    end
  end

`ifdef M_CLK_DIV_TICK_EN
  always_ff @(posedge clk) begin
    if (rst) clk_tick <= 1'b0;
    else     clk_tick <= clk_out_d && !clk_out;
  end
`endif

endmodule
